// File: rtl/conv_pkg.sv
// Shared definitions for the ConvKing datapath: default widths, feeder FSM states
// and the fixed add/sub select driven to mult_add.
package conv_pkg;

    localparam int DATA_W_DEF = 16;
    localparam int ACC_W_DEF  = 24;

    localparam logic IS_ADD = 1'b1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        DRAIN = 2'd2,
        OUT   = 2'd3
    } state_e;

endpackage

// File: rtl/mult_add_feeder_lat_tag_pipe.sv
// Latency tag pipe: marks which mult_add result cycles carry a real product.
// empty_o reports that no tag is left in flight once the current edge has shifted.
module lat_tag_pipe #(
    parameter int DEPTH = 2
) (
    input  logic sys_clk_i,
    input  logic sys_rst_n_i,
    input  logic push_i,
    output logic retire_o,
    output logic empty_o
);

    logic [DEPTH-1:0] stage_r;
    logic [DEPTH-1:0] stage_next_s;

    // Next contents: every tag moves one stage toward retire, push enters stage 0.
    always_comb begin
        stage_next_s = DEPTH'({stage_r, push_i});
    end

    assign retire_o = stage_r[DEPTH-1];
    assign empty_o  = (stage_next_s == {DEPTH{1'b0}});

    // Tag shift register.
    always_ff @(posedge sys_clk_i or negedge sys_rst_n_i) begin
        if (!sys_rst_n_i) begin
            stage_r <= {DEPTH{1'b0}};
        end else begin
            stage_r <= stage_next_s;
        end
    end

endmodule

// File: rtl/mult_add_feeder.sv
// Dot-product sequencer for the dual-MAC mult_add unit: packs element pairs into
// issues, tracks multiplier latency with tags and accumulates returned sums.
module mult_add_feeder
    import conv_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int ACC_W    = ACC_W_DEF,
    parameter int LEN_W    = 10,
    parameter int MULT_LAT = 2
) (
    input  logic              sys_clk_i,
    input  logic              sys_rst_n_i,
    input  logic              start_i,
    input  logic [LEN_W-1:0]  cfg_len_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [DATA_W-1:0] in_a_i,
    input  logic [DATA_W-1:0] in_b_i,
    output logic [DATA_W-1:0] am_num_A0_o,
    output logic [DATA_W-1:0] am_num_B0_o,
    output logic [DATA_W-1:0] am_num_A1_o,
    output logic [DATA_W-1:0] am_num_B1_o,
    output logic              sys_is_add_o,
    input  logic [DATA_W-1:0] am_mult_i,
    output logic              dp_valid_o,
    input  logic              dp_ready_i,
    output logic [ACC_W-1:0]  dp_sum_o,
    output logic              busy_o
);

    function automatic logic [ACC_W-1:0] sext(input logic [DATA_W-1:0] v);
        return {{(ACC_W-DATA_W){v[DATA_W-1]}}, v};
    endfunction

    state_e            state_r;
    logic [LEN_W-1:0]  len_r;
    logic [LEN_W-1:0]  cnt_r;
    logic [DATA_W-1:0] half_a_r;
    logic [DATA_W-1:0] half_b_r;
    logic [DATA_W-1:0] a0_r;
    logic [DATA_W-1:0] b0_r;
    logic [DATA_W-1:0] a1_r;
    logic [DATA_W-1:0] b1_r;
    logic              issue_r;
    logic [ACC_W-1:0]  acc_r;
    logic              in_ready_r;
    logic              dp_valid_r;
    logic              busy_r;

    logic accept_s;
    logic last_s;
    logic pair_done_s;
    logic retire_s;
    logic drained_s;
    logic job_start_s;

    assign accept_s    = in_valid_i & in_ready_r;
    assign last_s      = (cnt_r == (len_r - LEN_W'(1)));
    assign pair_done_s = accept_s & (cnt_r[0] | last_s);
    assign job_start_s = (state_r == IDLE) & start_i;

    // issue_r is high while freshly issued operands sit on mult_add, so the tag
    // retires exactly in the cycle that operand set's product is presented.
    lat_tag_pipe #(
        .DEPTH (MULT_LAT)
    ) u_tag_pipe (
        .sys_clk_i   (sys_clk_i),
        .sys_rst_n_i (sys_rst_n_i),
        .push_i      (issue_r),
        .retire_o    (retire_s),
        .empty_o     (drained_s)
    );

    // Job sequencing with registered handshake and status outputs.
    always_ff @(posedge sys_clk_i or negedge sys_rst_n_i) begin
        if (!sys_rst_n_i) begin
            state_r    <= IDLE;
            len_r      <= {LEN_W{1'b0}};
            cnt_r      <= {LEN_W{1'b0}};
            in_ready_r <= 1'b0;
            dp_valid_r <= 1'b0;
            busy_r     <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (start_i) begin
                        busy_r <= 1'b1;
                        len_r  <= cfg_len_i;
                        cnt_r  <= {LEN_W{1'b0}};
                        if (cfg_len_i != {LEN_W{1'b0}}) begin
                            state_r    <= LOAD;
                            in_ready_r <= 1'b1;
                        end else begin
                            state_r    <= OUT;
                            dp_valid_r <= 1'b1;
                        end
                    end
                end
                LOAD: begin
                    if (accept_s) begin
                        cnt_r <= cnt_r + LEN_W'(1);
                        if (last_s) begin
                            state_r    <= DRAIN;
                            in_ready_r <= 1'b0;
                        end
                    end
                end
                DRAIN: begin
                    if (drained_s) begin
                        state_r    <= OUT;
                        dp_valid_r <= 1'b1;
                    end
                end
                OUT: begin
                    if (dp_ready_i) begin
                        state_r    <= IDLE;
                        dp_valid_r <= 1'b0;
                        busy_r     <= 1'b0;
                    end
                end
                default: begin
                    state_r    <= IDLE;
                    in_ready_r <= 1'b0;
                    dp_valid_r <= 1'b0;
                    busy_r     <= 1'b0;
                end
            endcase
        end
    end

    // Half-pair holding and operand issue; operands keep their value between issues.
    always_ff @(posedge sys_clk_i or negedge sys_rst_n_i) begin
        if (!sys_rst_n_i) begin
            half_a_r <= {DATA_W{1'b0}};
            half_b_r <= {DATA_W{1'b0}};
            a0_r     <= {DATA_W{1'b0}};
            b0_r     <= {DATA_W{1'b0}};
            a1_r     <= {DATA_W{1'b0}};
            b1_r     <= {DATA_W{1'b0}};
            issue_r  <= 1'b0;
        end else begin
            issue_r <= pair_done_s;
            if (accept_s) begin
                if (!cnt_r[0]) begin
                    half_a_r <= in_a_i;
                    half_b_r <= in_b_i;
                    if (last_s) begin
                        a0_r <= in_a_i;
                        b0_r <= in_b_i;
                        a1_r <= {DATA_W{1'b0}};
                        b1_r <= {DATA_W{1'b0}};
                    end
                end else begin
                    a0_r <= half_a_r;
                    b0_r <= half_b_r;
                    a1_r <= in_a_i;
                    b1_r <= in_b_i;
                end
            end
        end
    end

    // Accumulator: cleared on job start, adds each tagged result with wraparound.
    always_ff @(posedge sys_clk_i or negedge sys_rst_n_i) begin
        if (!sys_rst_n_i) begin
            acc_r <= {ACC_W{1'b0}};
        end else if (job_start_s) begin
            acc_r <= {ACC_W{1'b0}};
        end else if (retire_s) begin
            acc_r <= acc_r + sext(am_mult_i);
        end
    end

    assign in_ready_o   = in_ready_r;
    assign dp_valid_o   = dp_valid_r;
    assign dp_sum_o     = acc_r;
    assign busy_o       = busy_r;
    assign am_num_A0_o  = a0_r;
    assign am_num_B0_o  = b0_r;
    assign am_num_A1_o  = a1_r;
    assign am_num_B1_o  = b1_r;
    assign sys_is_add_o = IS_ADD;

endmodule
